// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared constants, FSM state type and one-hot helper for rr_mux_arb4
package rr_mux_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] onehot_of(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_mux_arb4_if.sv
// rtl/rr_mux_arb4_if.sv - requester/arbiter bus for rr_mux_arb4; lock exists only with RR_MUX_LOCK_EN
interface rr_mux_arb4_if;
    import rr_mux_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] d;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               busy;
    logic               y;
`ifdef RR_MUX_LOCK_EN
    logic               lock;

    modport master (output req, d, lock, input gnt, sel, busy, y);
    modport slave  (input req, d, lock, output gnt, sel, busy, y);
`else
    modport master (output req, d, input gnt, sel, busy, y);
    modport slave  (input req, d, output gnt, sel, busy, y);
`endif

endinterface

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker starting the search at ptr
module rr_pick4
    import rr_mux_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the closest request to ptr is assigned last and wins.
    always_comb begin
        valid  = 1'b0;
        idx    = ptr;
        w_cand = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = ptr + i[SEL_W-1:0];
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb4.sv
// rtl/rr_mux_arb4.sv - round-robin 4:1 1-bit channel arbiter with bounded tenures; RR_MUX_LOCK_EN adds owner lock
module rr_mux_arb4
    import rr_mux_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rr_mux_arb4_if.slave    bus
);

    localparam int               CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_LEN - 1);

    arb_state_t          r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_ptr;
    logic [CNT_W-1:0]    r_cnt;

    logic                w_valid;
    logic [SEL_W-1:0]    w_idx;
    logic                w_lock_hold;
    logic                w_at_max;
    logic                w_tenure_end;
    logic                w_arb;

    rr_pick4 u_pick (
        .req   (bus.req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

`ifdef RR_MUX_LOCK_EN
    assign w_lock_hold = bus.lock;
`else
    assign w_lock_hold = 1'b0;
`endif

    assign w_at_max     = (r_cnt == CNT_MAX);
    assign w_tenure_end = (r_state == GRANT) &&
                          (!bus.req[r_sel] || (w_at_max && !w_lock_hold));
    assign w_arb        = (r_state == IDLE) || w_tenure_end;

    // Holding at CNT_MAX only happens under lock, which gives the saturation behaviour for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else if (w_arb) begin
            r_cnt <= '0;
            if (w_valid) begin
                r_state <= GRANT;
                r_gnt   <= onehot_of(w_idx);
                r_sel   <= w_idx;
                r_ptr   <= w_idx + 2'd1;
            end else begin
                r_state <= IDLE;
                r_gnt   <= '0;
            end
        end else if (!w_at_max) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.gnt  = r_gnt;
    assign bus.sel  = r_sel;
    assign bus.busy = (r_state == GRANT);
    assign bus.y    = (r_state == GRANT) ? bus.d[r_sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arb4.sv
// tb/tb_rr_mux_arb4.sv - directed self-checking bench for rr_mux_arb4 (lock scenario with RR_MUX_LOCK_EN)
module tb_rr_mux_arb4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    rr_mux_arb4_if bus ();

    rr_mux_arb4 #(.BURST_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 4'b0000;
        bus.d   = 4'b0000;
`ifdef RR_MUX_LOCK_EN
        bus.lock = 1'b0;
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        bus.d   = 4'b1111;
`ifdef RR_MUX_LOCK_EN
        bus.lock = 1'b0;
`endif
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt cyc%0d got %b want 0000", i, bus.gnt); end
            n_cmp++;
            if (bus.sel !== 2'd0) begin n_err++; $display("FAIL reset_sel cyc%0d got %0d want 0", i, bus.sel); end
            n_cmp++;
            if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy cyc%0d got %b want 0", i, bus.busy); end
            n_cmp++;
            if (bus.y !== 1'b0) begin n_err++; $display("FAIL reset_y cyc%0d got %b want 0", i, bus.y); end
        end
        bus.req = 4'b0000;
        rst_n   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset busy got %b want 0", bus.busy); end
    endtask

    task automatic test_sole_requester();
        logic [3:0] dv;
        do_reset();
        bus.req = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0100) begin n_err++; $display("FAIL sole_gnt cyc%0d got %b want 0100", i, bus.gnt); end
            n_cmp++;
            if (bus.sel !== 2'd2) begin n_err++; $display("FAIL sole_sel cyc%0d got %0d want 2", i, bus.sel); end
            dv    = 4'b1011;
            dv[2] = i[0];
            bus.d = dv;
            #1;
            n_cmp++;
            if (bus.y !== i[0]) begin n_err++; $display("FAIL sole_y cyc%0d got %b want %b", i, bus.y, i[0]); end
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
            n_err++; $display("FAIL sole_end busy=%b gnt=%b want 0/0000", bus.busy, bus.gnt);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [4];
        logic       exp_y   [4];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        exp_y   = '{1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        bus.req = 4'b1111;
        bus.d   = 4'b1010;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== exp_gnt[(c / 4) % 4]) begin
                n_err++; $display("FAIL rr_gnt cyc%0d got %b want %b", c, bus.gnt, exp_gnt[(c / 4) % 4]);
            end
            n_cmp++;
            if (bus.y !== exp_y[(c / 4) % 4]) begin
                n_err++; $display("FAIL rr_y cyc%0d got %b want %b", c, bus.y, exp_y[(c / 4) % 4]);
            end
        end
        bus.req = 4'b0000;
        @(negedge clk);
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr_idle busy got %b want 0", bus.busy); end
    endtask

    task automatic test_release_back_to_back();
        do_reset();
        bus.d   = 4'b1000;
        bus.req = 4'b0010;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL rel_first got %b want 0010", bus.gnt); end
        bus.req = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        bus.req = 4'b1000;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL rel_release_cycle got %b want 0010", bus.gnt); end
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b1000 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL rel_next gnt=%b busy=%b want 1000/1", bus.gnt, bus.busy);
        end
        n_cmp++;
        if (bus.sel !== 2'd3 || bus.y !== 1'b1) begin
            n_err++; $display("FAIL rel_next_sel sel=%0d y=%b want 3/1", bus.sel, bus.y);
        end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_tenure();
        do_reset();
        bus.d   = 4'b0100;
        bus.req = 4'b0100;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0100 || bus.y !== 1'b1) begin
            n_err++; $display("FAIL mid_pre gnt=%b y=%b want 0100/1", bus.gnt, bus.y);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.y !== 1'b0) begin
            n_err++; $display("FAIL mid_async gnt=%b busy=%b y=%b want 0000/0/0", bus.gnt, bus.busy, bus.y);
        end
        bus.req = 4'b1111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL mid_first_after got %b want 0001", bus.gnt); end
        bus.req = 4'b0000;
        @(negedge clk);
    endtask

`ifdef RR_MUX_LOCK_EN
    task automatic test_lock();
        do_reset();
        bus.lock = 1'b1;
        bus.req  = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL lock_hold cyc%0d got %b want 0001", i, bus.gnt); end
        end
        bus.req = 4'b0010;
        #1;
        n_cmp++;
        if (bus.gnt !== 4'b0001) begin n_err++; $display("FAIL lock_release_cycle got %b want 0001", bus.gnt); end
        @(negedge clk);
        n_cmp++;
        if (bus.gnt !== 4'b0010) begin n_err++; $display("FAIL lock_next got %b want 0010", bus.gnt); end
        bus.lock = 1'b0;
        bus.req  = 4'b0000;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_sole_requester();
        test_round_robin();
        test_release_back_to_back();
        test_reset_mid_tenure();
`ifdef RR_MUX_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
